// File: rtl/mem_io_responder_pkg.sv
// Shared address map, status-bit layout and bus decode for the memory/IO responder.
package mem_io_responder_pkg;

    localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
    localparam logic [17:0] IO_CTRL_ADDR = 18'h30004;

    // Bit positions inside the IO_CTRL status byte
    localparam int unsigned STAT_RX_NONEMPTY = 0;
    localparam int unsigned STAT_BUF_FULL    = 1;
    localparam int unsigned STAT_TX_OVERFLOW = 2;

    typedef enum logic [1:0] {
        SelRam,
        SelIoData,
        SelIoCtrl,
        SelIoOther
    } sel_e;

    function automatic logic io_region(input logic [17:0] a);
        return a[17:16] == 2'b11;
    endfunction

    function automatic sel_e decode_addr(input logic [17:0] a);
        if (!io_region(a))          return SelRam;
        else if (a == IO_DATA_ADDR) return SelIoData;
        else if (a == IO_CTRL_ADDR) return SelIoCtrl;
        else                        return SelIoOther;
    endfunction

endpackage

// File: rtl/mem_io_responder_fifo.sv
// Synchronous byte FIFO with show-ahead head; a pop on a full FIFO frees room for a same-cycle push.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned Aw = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [Aw-1:0] rd_ptr_q, wr_ptr_q;
    logic [Aw:0]   count_q;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (Aw + 1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign do_pop  = en && pop && !empty;
    assign do_push = en && push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + Aw'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + Aw'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (Aw + 1)'(1);
                2'b01:   count_q <= count_q - (Aw + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Target end of the byte-serial memory bus: byte RAM plus an IO window with console FIFOs,
// status and halt. Loads return data one cycle after the address is presented.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned RAM_AW      = 17,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned RX_DEPTH    = 16,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] bus_a,
    input  logic        bus_wr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_full,
    output logic        halt,
    output logic        tx_overflow
);
    localparam int unsigned TxCw = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RxCw = $clog2(RX_DEPTH) + 1;

    logic [7:0] mem [2**RAM_AW];

    sel_e              sel;
    logic [RAM_AW-1:0] ram_addr;
    logic              unused_addr;

    assign sel         = decode_addr(bus_a[17:0]);
    assign ram_addr    = bus_a[RAM_AW-1:0];
    assign unused_addr = ^bus_a[31:18];

    logic            tx_push, tx_empty, tx_full;
    logic [TxCw-1:0] tx_count;
    logic            rx_push, rx_pop, rx_empty;
    logic [7:0]      rx_head;
    logic [RxCw-1:0] rx_count;
    logic            rx_count_unused;

    assign tx_push         = bus_wr && (sel == SelIoData);
    assign rx_pop          = !bus_wr && (sel == SelIoData);
    assign rx_push         = rx_valid && !rx_full;
    assign rx_count_unused = ^rx_count;

    byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .push  (tx_push),
        .din   (bus_wdata),
        .pop   (tx_ready),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    byte_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .push  (rx_push),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    assign tx_valid = !tx_empty;

    // Margin absorbs stores the controller already has in flight
    assign io_buffer_full = (TX_DEPTH - 32'(tx_count)) <= FULL_MARGIN;

    logic [7:0] rdata_q, rdata_d;
    logic       halt_q, halt_d;
    logic       tx_ovf_q, tx_ovf_d;
    logic [7:0] status;

    always_comb begin
        status                   = 8'h00;
        status[STAT_RX_NONEMPTY] = !rx_empty;
        status[STAT_BUF_FULL]    = io_buffer_full;
        status[STAT_TX_OVERFLOW] = tx_ovf_q;
    end

    always_comb begin
        rdata_d = 8'h00;
        unique case (sel)
            SelRam:    rdata_d = mem[ram_addr];
            SelIoData: if (!bus_wr && !rx_empty) rdata_d = rx_head;
            SelIoCtrl: if (!bus_wr) rdata_d = status;
            default:   rdata_d = 8'h00;
        endcase
    end

    // A full-FIFO store is only lost if the consumer is not popping in the same cycle
    assign tx_ovf_d = tx_ovf_q || (tx_push && tx_full && !tx_ready);
    assign halt_d   = halt_q || (bus_wr && (sel == SelIoCtrl));

    always_ff @(posedge clk) begin
        if (rdy && bus_wr && (sel == SelRam)) mem[ram_addr] <= bus_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= 8'h00;
            halt_q   <= 1'b0;
            tx_ovf_q <= 1'b0;
        end else if (rdy) begin
            rdata_q  <= rdata_d;
            halt_q   <= halt_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end

    assign bus_rdata   = rdata_q;
    assign halt        = halt_q;
    assign tx_overflow = tx_ovf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: loads queue expected bytes, a monitor checks bus_rdata.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] bus_a = '0;
    logic        bus_wr = 1'b0;
    logic [7:0]  bus_wdata = '0;
    logic [7:0]  bus_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_full;
    logic        halt;
    logic        tx_overflow;

    logic        chk_load = 1'b0;
    logic        resp_due = 1'b0;
    logic [7:0]  exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mem_io_responder dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .bus_a          (bus_a),
        .bus_wr         (bus_wr),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_full        (rx_full),
        .halt           (halt),
        .tx_overflow    (tx_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A load accepted at an edge is answered on bus_rdata by the following negedge
    always @(posedge clk) resp_due <= chk_load && rdy && !rst;

    always @(negedge clk) begin
        if (resp_due) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow: got 0x%0h expected none", bus_rdata);
            end else begin
                check(name_q.pop_front(), 32'(bus_rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d,
                         input logic c, input logic [7:0] e, input string n);
        @(negedge clk);
        rdy       = r;
        bus_a     = a;
        bus_wr    = w;
        bus_wdata = d;
        chk_load  = c;
        if (c) begin
            exp_q.push_back(e);
            name_q.push_back(n);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [7:0] d);
        drive(1'b1, a, 1'b1, d, 1'b0, 8'h00, "");
    endtask

    task automatic load(input logic [31:0] a, input logic [7:0] e, input string n);
        drive(1'b1, a, 1'b0, 8'h00, 1'b1, e, n);
    endtask

    task automatic idle();
        drive(1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, "");
    endtask

    task automatic rx_push(input logic [7:0] d);
        idle();
        rx_valid = 1'b1;
        rx_data  = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dut.mem[17'h101] = 8'h5C;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_rdata", 32'(bus_rdata), 32'h00);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_rx_full", 32'(rx_full), 32'h0);
        check("rst_halt", 32'(halt), 32'h0);
        check("rst_tx_overflow", 32'(tx_overflow), 32'h0);
        check("rst_buf_full", 32'(io_buffer_full), 32'h0);

        // RAM store/load, store-then-load forwarding, untouched preload
        store(32'h100, 8'hA5);
        load(32'h100, 8'hA5, "ram_0x100");
        load(32'h101, 8'h5C, "ram_preload_0x101");
        store(32'h10, 8'h66);
        load(32'h10, 8'h66, "ram_0x10");
        load(32'hFFFC_0100, 8'hA5, "ram_upper_bits_ignored");
        load(32'h30008, 8'h00, "io_other_offset");

        // TX path: near-full threshold, then drain in order
        for (int i = 0; i < 13; i++) store(32'h30000, 8'(8'h41 + i));
        idle();
        check("buf_full_after_13", 32'(io_buffer_full), 32'h0);
        store(32'h30000, 8'h4E);
        idle();
        check("buf_full_after_14", 32'(io_buffer_full), 32'h1);
        load(32'h30004, 8'h02, "ctrl_buf_full");
        for (int i = 0; i < 14; i++) begin
            idle();
            if (i == 0) tx_ready = 1'b1;
            check("tx_valid_drain", 32'(tx_valid), 32'h1);
            check("tx_data_drain", 32'(tx_data), 32'(8'h41 + i));
        end
        idle();
        tx_ready = 1'b0;
        check("tx_valid_empty", 32'(tx_valid), 32'h0);
        check("buf_full_empty", 32'(io_buffer_full), 32'h0);

        // TX overflow: 17th store dropped
        for (int i = 0; i < 17; i++) store(32'h30000, 8'(8'h50 + i));
        idle();
        check("tx_overflow_set", 32'(tx_overflow), 32'h1);
        load(32'h30004, 8'h06, "ctrl_overflow");
        for (int i = 0; i < 16; i++) begin
            idle();
            if (i == 0) tx_ready = 1'b1;
            check("tx_ovf_data", 32'(tx_data), 32'(8'h50 + i));
        end
        idle();
        tx_ready = 1'b0;
        check("tx_ovf_empty", 32'(tx_valid), 32'h0);

        // RX path
        rx_push(8'h31);
        rx_push(8'h32);
        idle();
        rx_valid = 1'b0;
        load(32'h30000, 8'h31, "rx_first");
        load(32'h30000, 8'h32, "rx_second");
        load(32'h30000, 8'h00, "rx_empty_load");
        load(32'h30004, 8'h04, "ctrl_rx_empty");

        // RX full: 17th push refused
        for (int i = 0; i < 17; i++) rx_push(8'(8'h80 + i));
        idle();
        rx_valid = 1'b0;
        check("rx_full_set", 32'(rx_full), 32'h1);
        for (int i = 0; i < 17; i++) load(32'h30000, (i < 16) ? 8'(8'h80 + i) : 8'h00, "rx_fill");
        idle();
        check("rx_full_clear", 32'(rx_full), 32'h0);

        // Halt
        store(32'h30004, 8'h99);
        idle();
        check("halt_set", 32'(halt), 32'h1);
        idle();
        idle();
        check("halt_sticky", 32'(halt), 32'h1);

        // rdy low freezes everything
        load(32'h100, 8'hA5, "pre_stall");
        drive(1'b0, 32'h10, 1'b1, 8'h77, 1'b0, 8'h00, "");
        drive(1'b0, 32'h30000, 1'b1, 8'h55, 1'b0, 8'h00, "");
        drive(1'b0, 32'h101, 1'b0, 8'h00, 1'b0, 8'h00, "");
        check("stall_rdata_hold", 32'(bus_rdata), 32'hA5);
        check("stall_no_tx_push", 32'(tx_valid), 32'h0);
        check("stall_halt_hold", 32'(halt), 32'h1);
        check("stall_ovf_hold", 32'(tx_overflow), 32'h1);
        load(32'h10, 8'h66, "stall_no_ram_write");

        // Reset mid-operation
        for (int i = 0; i < 5; i++) store(32'h30000, 8'(8'hC0 + i));
        for (int i = 0; i < 3; i++) rx_push(8'(8'hD0 + i));
        idle();
        rx_valid = 1'b0;
        check("pre_rst_tx_valid", 32'(tx_valid), 32'h1);
        load(32'h30004, 8'h05, "pre_rst_ctrl");
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
        check("mid_rst_rx_full", 32'(rx_full), 32'h0);
        check("mid_rst_halt", 32'(halt), 32'h0);
        check("mid_rst_overflow", 32'(tx_overflow), 32'h0);
        check("mid_rst_rdata", 32'(bus_rdata), 32'h00);
        load(32'h100, 8'hA5, "ram_kept_after_rst");
        load(32'h30000, 8'h00, "rx_discarded");
        load(32'h30004, 8'h00, "ctrl_after_rst");
        idle();
        idle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
